// File: rtl/tx_pattern_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : tx_pattern_gen_if
//  Description : User-data valid/ready handshake into the transmit pattern
//                generator.
//                  data_in    : 8-bit user word
//                  data_valid : data_in carries a word
//                  data_ready : generator accepts data_in this cycle
//                master = word producer, slave = tx_pattern_gen.
//  Revision    : 1.0  initial release
// ============================================================================
interface tx_pattern_gen_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );
endinterface
`default_nettype wire

// File: rtl/tx_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tx_pattern_gen
//  Description : Transmit word source for an 8-bit serializer. Sends an idle
//                word, a PRBS7 (x^7+x^6+1) training burst, or user data, and
//                keeps saturating counters of sent and corrupted words.
//                Optional single-bit error injection is built in when the
//                macro TX_ERR_INJECT_EN is defined.
//  Ports       : clk160          rising-edge clock
//                rst             synchronous active-high reset
//                train_start     pulse: start / restart a training burst
//                train_hold      keep training past the end of the burst
//                data_en         go to / stay in the DATA state
//                data_if         user-data handshake (slave modport)
//                inject_err      pulse: corrupt bit 0 of the next sent word
//                reset_counters  synchronous clear of both counters
//                tx_word         registered word to the serializer (bit 0 first)
//                train_active    high while training
//                train_done      one-cycle pulse when a burst completes
//                words_sent      saturating count of PRBS + accepted data words
//                errs_injected   saturating count of injected errors
//  Revision    : 1.0  initial release
// ============================================================================
module tx_pattern_gen #(
    parameter int unsigned TRAIN_WORDS = 1024,
    parameter logic [7:0]  IDLE_WORD   = 8'hAC,
    parameter logic [6:0]  PRBS_SEED   = 7'h7F
) (
    input  wire logic         clk160,
    input  wire logic         rst,
    input  wire logic         train_start,
    input  wire logic         train_hold,
    input  wire logic         data_en,
    tx_pattern_gen_if.slave   data_if,
    input  wire logic         inject_err,
    input  wire logic         reset_counters,
    output logic [7:0]        tx_word,
    output logic              train_active,
    output logic              train_done,
    output logic [31:0]       words_sent,
    output logic [15:0]       errs_injected
);

    localparam logic [15:0] c_burst_load = 16'(TRAIN_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAIN = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [6:0]  r_lfsr, w_lfsr_nxt;
    logic [15:0] r_burst_cnt, w_burst_cnt_nxt;
    logic [7:0]  r_tx_word;
    logic        r_train_done, w_done_nxt;
    logic [31:0] r_words_sent;
    logic [7:0]  w_word_sel;
    logic [7:0]  w_word_tx;
    logic        w_sent;
    logic        w_accept;
    logic        w_err_apply;
    logic [14:0] w_prbs;

    // Eight LFSR steps; returns {next_state, word}, word bit k = k-th new bit.
    function automatic logic [14:0] prbs_step(input logic [6:0] s_in);
        logic [6:0] s;
        logic [7:0] w;
        logic       b;
        s = s_in;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            b    = s[6] ^ s[5];
            s    = {s[5:0], b};
            w[k] = b;
        end
        return {s, w};
    endfunction

    assign w_prbs = prbs_step(r_lfsr);

    // A start request takes the cycle, so no user word is accepted alongside it.
    assign data_if.data_ready = (r_state == ST_DATA) && data_en && !train_start;
    assign w_accept           = data_if.data_ready && data_if.data_valid;

    always_comb begin
        w_state_nxt     = r_state;
        w_lfsr_nxt      = r_lfsr;
        w_burst_cnt_nxt = r_burst_cnt;
        w_word_sel      = IDLE_WORD;
        w_sent          = 1'b0;
        w_done_nxt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (train_start) begin
                    w_state_nxt     = ST_TRAIN;
                    w_lfsr_nxt      = PRBS_SEED;
                    w_burst_cnt_nxt = c_burst_load;
                end else if (data_en) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_TRAIN: begin
                if (train_start) begin
                    // Restart: the restart cycle itself emits an idle word.
                    w_lfsr_nxt      = PRBS_SEED;
                    w_burst_cnt_nxt = c_burst_load;
                end else begin
                    w_word_sel = w_prbs[7:0];
                    w_lfsr_nxt = w_prbs[14:8];
                    w_sent     = 1'b1;
                    if (r_burst_cnt != 16'd0) begin
                        w_burst_cnt_nxt = r_burst_cnt - 16'd1;
                    end else if (!train_hold) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = data_en ? ST_DATA : ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (train_start) begin
                    w_state_nxt     = ST_TRAIN;
                    w_lfsr_nxt      = PRBS_SEED;
                    w_burst_cnt_nxt = c_burst_load;
                end else if (!data_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_accept) begin
                    w_word_sel = data_if.data_in;
                    w_sent     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_word_tx = w_word_sel ^ {7'd0, w_err_apply};

    always_ff @(posedge clk160) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_tx_word    <= IDLE_WORD;
            r_lfsr       <= PRBS_SEED;
            r_burst_cnt  <= 16'd0;
            r_train_done <= 1'b0;
            r_words_sent <= 32'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_tx_word    <= w_word_tx;
            r_lfsr       <= w_lfsr_nxt;
            r_burst_cnt  <= w_burst_cnt_nxt;
            r_train_done <= w_done_nxt;
            if (reset_counters) begin
                r_words_sent <= 32'd0;
            end else if (w_sent && (r_words_sent != 32'hFFFF_FFFF)) begin
                r_words_sent <= r_words_sent + 32'd1;
            end
        end
    end

`ifdef TX_ERR_INJECT_EN
    logic        r_err_pend;
    logic [15:0] r_errs;

    // Idle words never consume the pending flag.
    assign w_err_apply = r_err_pend && w_sent;

    always_ff @(posedge clk160) begin
        if (rst) begin
            r_err_pend <= 1'b0;
            r_errs     <= 16'd0;
        end else begin
            // A pulse landing while a request is outstanding merges into it.
            if (w_err_apply) begin
                r_err_pend <= 1'b0;
            end else if (inject_err) begin
                r_err_pend <= 1'b1;
            end
            if (reset_counters) begin
                r_errs <= 16'd0;
            end else if (w_err_apply && (r_errs != 16'hFFFF)) begin
                r_errs <= r_errs + 16'd1;
            end
        end
    end

    assign errs_injected = r_errs;
`else
    logic w_unused_inject;
    assign w_unused_inject = inject_err;
    assign w_err_apply     = 1'b0;
    assign errs_injected   = 16'd0;
`endif

    assign tx_word      = r_tx_word;
    assign train_active = (r_state == ST_TRAIN);
    assign train_done   = r_train_done;
    assign words_sent   = r_words_sent;

endmodule
`default_nettype wire
